// File: rtl/mac_arbiter_pkg.sv
// Shared types and constants for the two-port multiplier arbiter.
// Arbitration policy is selected by MAC_ARB_RR_EN (see mac_arbiter.sv).
package mac_arbiter_pkg;

  localparam int unsigned XLEN_W = 32;
  localparam int unsigned OP_W   = 5;

  localparam logic [OP_W-1:0] OP_MUL    = 5'd10;
  localparam logic [OP_W-1:0] OP_MULH   = 5'd11;
  localparam logic [OP_W-1:0] OP_MULHU  = 5'd12;
  localparam logic [OP_W-1:0] OP_MULHSU = 5'd13;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  typedef logic [0:0] port_id_t;

  typedef struct packed {
    logic [XLEN_W-1:0] a;
    logic [XLEN_W-1:0] b;
    logic [OP_W-1:0]   op;
  } mac_req_t;

endpackage

// File: rtl/mac_arbiter_if.sv
// Request/response channel of one multiplier client (core or FFT engine).
interface mac_arbiter_if;
  import mac_arbiter_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [XLEN_W-1:0] a;
  logic [XLEN_W-1:0] b;
  logic [OP_W-1:0]   op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, a, b, op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, a, b, op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/mac_arbiter_mul.sv
// Combinational 32x32 multiplier covering MUL/MULH/MULHU/MULHSU.
// Unknown op codes produce zero data with the error flag raised.
module mac_arbiter_mul
  import mac_arbiter_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [OP_W-1:0] op,
  output logic [XLEN-1:0] data_c,
  output logic            err_c
);

  localparam int unsigned EXT_W  = XLEN + 1;
  localparam int unsigned PROD_W = 2 * XLEN;

  logic                     a_sgn;
  logic                     b_sgn;
  logic signed [EXT_W-1:0]  a_ext;
  logic signed [EXT_W-1:0]  b_ext;
  logic signed [PROD_W-1:0] prod;

  // Per-op operand signedness; one signed multiplier serves all four ops
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    err_c = 1'b0;
    case (op)
      OP_MUL:    ;
      OP_MULH:   begin a_sgn = 1'b1; b_sgn = 1'b1; end
      OP_MULHU:  ;
      OP_MULHSU: a_sgn = 1'b1;
      default:   err_c = 1'b1;
    endcase
  end

  assign a_ext = $signed({a_sgn & a[XLEN-1], a});
  assign b_ext = $signed({b_sgn & b[XLEN-1], b});
  assign prod  = PROD_W'(a_ext) * PROD_W'(b_ext);

  always_comb begin
    data_c = '0;
    if (!err_c) begin
      data_c = (op == OP_MUL) ? prod[XLEN-1:0] : prod[PROD_W-1:XLEN];
    end
  end

endmodule

// File: rtl/mac_arbiter.sv
// Shares one multiplier between the core (p0) and FFT engine (p1), one
// transaction in flight. MAC_ARB_RR_EN: round-robin; otherwise p0 has priority.
module mac_arbiter
  import mac_arbiter_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  mac_arbiter_if.slave  p0,
  mac_arbiter_if.slave  p1,
  output logic          busy
);

  state_t          state;
  port_id_t        gnt_id;
  port_id_t        sel_c;
  logic            any_req_c;
  logic            accept_c;
  logic            fire_c;
  logic [1:0]      port_mask_c;
  mac_req_t        req_c;
  logic [XLEN-1:0] mul_data_c;
  logic            mul_err_c;
  logic [XLEN-1:0] rsp_data_q;
  logic [1:0]      rsp_valid_q;
  logic [1:0]      rsp_err_q;
`ifdef MAC_ARB_RR_EN
  port_id_t        rr_ptr;
`endif

  // Grant selection and request mux
  always_comb begin
    any_req_c = p0.req_valid | p1.req_valid;
`ifdef MAC_ARB_RR_EN
    if (p0.req_valid && p1.req_valid) begin
      sel_c = rr_ptr;
    end else begin
      sel_c = port_id_t'(p1.req_valid);
    end
`else
    sel_c = port_id_t'(!p0.req_valid);
`endif
    accept_c    = (state == ST_IDLE) && !rst && any_req_c;
    port_mask_c = (sel_c == 1'b1) ? 2'b10 : 2'b01;
    if (sel_c == 1'b1) begin
      req_c = '{a: p1.a, b: p1.b, op: p1.op};
    end else begin
      req_c = '{a: p0.a, b: p0.b, op: p0.op};
    end
    fire_c = (gnt_id == 1'b1) ? p1.rsp_ready : p0.rsp_ready;
  end

  mac_arbiter_mul #(.XLEN(XLEN)) u_mul (
    .a      (req_c.a),
    .b      (req_c.b),
    .op     (req_c.op),
    .data_c (mul_data_c),
    .err_c  (mul_err_c)
  );

  // Result is captured on the accept edge so rsp_valid rises one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      gnt_id      <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 2'b00;
`ifdef MAC_ARB_RR_EN
      rr_ptr      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            state       <= ST_RESP;
            busy        <= 1'b1;
            gnt_id      <= sel_c;
            rsp_data_q  <= mul_data_c;
            rsp_valid_q <= port_mask_c;
            rsp_err_q   <= mul_err_c ? port_mask_c : 2'b00;
`ifdef MAC_ARB_RR_EN
            rr_ptr      <= ~sel_c;
`endif
          end
        end
        ST_RESP: begin
          if (fire_c) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 2'b00;
          end
        end
      endcase
    end
  end

  assign p0.req_ready = accept_c & (sel_c == 1'b0);
  assign p1.req_ready = accept_c & (sel_c == 1'b1);
  assign p0.rsp_valid = rsp_valid_q[0];
  assign p1.rsp_valid = rsp_valid_q[1];
  assign p0.rsp_err   = rsp_err_q[0];
  assign p1.rsp_err   = rsp_err_q[1];
  assign p0.rsp_data  = rsp_data_q;
  assign p1.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mac_arbiter.sv
// Randomized self-checking bench for mac_arbiter against a 64-bit arithmetic
// reference model; builds with or without MAC_ARB_RR_EN.
module tb_mac_arbiter;
  import mac_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  mac_arbiter_if p0_if ();
  mac_arbiter_if p1_if ();

  mac_arbiter #(.XLEN(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .p0   (p0_if),
    .p1   (p1_if),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int passes   = 0;
  int last_gnt = -1;

  // Reference: {err, data} from full-width 64-bit products
  function automatic logic [32:0] ref_mac(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      5'd10: begin p = ua * ub; return {1'b0, p[31:0]}; end
      5'd11: begin p = sa * sb; return {1'b0, p[63:32]}; end
      5'd12: begin p = ua * ub; return {1'b0, p[63:32]}; end
      5'd13: begin p = sa * longint'(ub); return {1'b0, p[63:32]}; end
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  // Expected winner from the arbitration rules
  function automatic int pick(input bit v0, input bit v1);
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
`ifdef MAC_ARB_RR_EN
    return (last_gnt == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic do_txn(input string tag, input bit v0, input bit v1,
                        input logic [4:0] op0, input logic [4:0] op1,
                        input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1,
                        input int stall);
    int          w;
    logic [32:0] exp;
    logic [1:0]  mask, rdy, rv, re;
    logic [31:0] rd;
    w    = pick(v0, v1);
    exp  = (w == 0) ? ref_mac(op0, a0, b0) : ref_mac(op1, a1, b1);
    mask = (w == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    p0_if.req_valid = v0; p0_if.op = op0; p0_if.a = a0; p0_if.b = b0;
    p1_if.req_valid = v1; p1_if.op = op1; p1_if.a = a1; p1_if.b = b1;
    p0_if.rsp_ready = 1'b0; p1_if.rsp_ready = 1'b0;
    #1;
    rdy = {p1_if.req_ready, p0_if.req_ready};
    checks++;
    if (rdy !== mask) $display("FAIL %s grant req_ready: got %b expected %b", tag, rdy, mask);
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL %s idle busy: got %b expected 0", tag, busy);
    else passes++;
    @(posedge clk);
    last_gnt = w;
    for (int c = 0; c <= stall; c++) begin
      @(negedge clk);
      p0_if.req_valid = 1'b1;
      p1_if.req_valid = 1'b1;
      // Non-granted port's rsp_ready must not complete the transaction
      if (w == 0) begin p0_if.rsp_ready = (c == stall); p1_if.rsp_ready = 1'b1; end
      else        begin p1_if.rsp_ready = (c == stall); p0_if.rsp_ready = 1'b1; end
      #1;
      rv  = {p1_if.rsp_valid, p0_if.rsp_valid};
      re  = {p1_if.rsp_err, p0_if.rsp_err};
      rd  = (w == 0) ? p0_if.rsp_data : p1_if.rsp_data;
      rdy = {p1_if.req_ready, p0_if.req_ready};
      checks++;
      if (rv !== mask) $display("FAIL %s rsp_valid c%0d: got %b expected %b", tag, c, rv, mask);
      else passes++;
      checks++;
      if (rd !== exp[31:0]) $display("FAIL %s rsp_data c%0d: got %h expected %h", tag, c, rd, exp[31:0]);
      else passes++;
      checks++;
      if (re !== (exp[32] ? mask : 2'b00))
        $display("FAIL %s rsp_err c%0d: got %b expected %b", tag, c, re, exp[32] ? mask : 2'b00);
      else passes++;
      checks++;
      if (rdy !== 2'b00) $display("FAIL %s resp req_ready c%0d: got %b expected 00", tag, c, rdy);
      else passes++;
      checks++;
      if (busy !== 1'b1) $display("FAIL %s resp busy c%0d: got %b expected 1", tag, c, busy);
      else passes++;
    end
    @(posedge clk);
    #1;
    p0_if.req_valid = 1'b0; p1_if.req_valid = 1'b0;
    p0_if.rsp_ready = 1'b0; p1_if.rsp_ready = 1'b0;
    rv = {p1_if.rsp_valid, p0_if.rsp_valid};
    checks++;
    if (rv !== 2'b00 || busy !== 1'b0)
      $display("FAIL %s release: got valid %b busy %b expected 00 0", tag, rv, busy);
    else passes++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    p0_if.req_valid = 1'b1; p0_if.op = OP_MUL; p0_if.a = 32'd3; p0_if.b = 32'd4;
    p1_if.req_valid = 1'b1; p1_if.op = OP_MUL; p1_if.a = 32'd5; p1_if.b = 32'd6;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({p1_if.rsp_valid, p0_if.rsp_valid} !== 2'b00 || busy !== 1'b0)
      $display("FAIL reset valid/busy: got %b %b expected 00 0",
               {p1_if.rsp_valid, p0_if.rsp_valid}, busy);
    else passes++;
    checks++;
    if (p0_if.rsp_data !== 32'd0 || {p1_if.rsp_err, p0_if.rsp_err} !== 2'b00)
      $display("FAIL reset data/err: got %h %b expected 0 00",
               p0_if.rsp_data, {p1_if.rsp_err, p0_if.rsp_err});
    else passes++;
    checks++;
    if ({p1_if.req_ready, p0_if.req_ready} !== 2'b00)
      $display("FAIL reset req_ready: got %b expected 00", {p1_if.req_ready, p0_if.req_ready});
    else passes++;
    rst = 1'b0;
    p0_if.req_valid = 1'b0; p1_if.req_valid = 1'b0;
    last_gnt = -1;
  endtask

  task automatic test_directed();
    do_txn("mul7x6", 1'b1, 1'b0, OP_MUL, 5'd0, 32'd7, 32'd6, 32'd0, 32'd0, 0);
    do_txn("mulh_m1", 1'b0, 1'b1, 5'd0, OP_MULH, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    do_txn("mulhu_m1", 1'b0, 1'b1, 5'd0, OP_MULHU, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    do_txn("mulhsu", 1'b0, 1'b1, 5'd0, OP_MULHSU, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd2, 0);
  endtask

  task automatic test_contention();
    for (int k = 0; k < 6; k++) begin
      do_txn("contend", 1'b1, 1'b1, OP_MUL, OP_MULHU, 32'(k + 1), 32'd3,
             32'(k + 100), 32'hDEADBEEF, 0);
    end
  endtask

  task automatic test_backpressure();
    do_txn("stall5", 1'b1, 1'b0, OP_MULHSU, 5'd0, 32'h80000000, 32'h12345678, 32'd0, 32'd0, 5);
  endtask

  task automatic test_err_reset();
    logic [1:0] rdy;
    @(negedge clk);
    p0_if.req_valid = 1'b1; p0_if.op = 5'd5; p0_if.a = 32'd9; p0_if.b = 32'd9;
    #1;
    rdy = {p1_if.req_ready, p0_if.req_ready};
    checks++;
    if (rdy !== 2'b01) $display("FAIL err_op accept: got %b expected 01", rdy);
    else passes++;
    @(posedge clk);
    @(negedge clk);
    p0_if.req_valid = 1'b0;
    #1;
    checks++;
    if (p0_if.rsp_valid !== 1'b1 || p0_if.rsp_err !== 1'b1 || p0_if.rsp_data !== 32'd0)
      $display("FAIL err_op rsp: got v%b e%b d%h expected v1 e1 d00000000",
               p0_if.rsp_valid, p0_if.rsp_err, p0_if.rsp_data);
    else passes++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({p1_if.rsp_valid, p0_if.rsp_valid} !== 2'b00 || busy !== 1'b0 || p0_if.rsp_err !== 1'b0)
      $display("FAIL rst_in_resp: got v%b busy %b err %b expected v00 busy 0 err 0",
               {p1_if.rsp_valid, p0_if.rsp_valid}, busy, p0_if.rsp_err);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    last_gnt = -1;
    // Pointer is back at port 0 after reset
    do_txn("post_rst", 1'b1, 1'b1, OP_MUL, OP_MUL, 32'd11, 32'd13, 32'd17, 32'd19, 0);
  endtask

  task automatic test_random();
    bit          v0, v1;
    logic [4:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    int          r;
    for (int n = 0; n < 40; n++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      r   = int'($urandom_range(0, 9));
      op0 = (r < 8) ? 5'(10 + (r % 4)) : 5'($urandom_range(0, 31));
      r   = int'($urandom_range(0, 9));
      op1 = (r < 8) ? 5'(10 + (r % 4)) : 5'($urandom_range(0, 31));
      r  = int'($urandom_range(0, 5));
      a0 = (r == 0) ? 32'hFFFFFFFF : (r == 1) ? 32'h80000000 : $urandom;
      b0 = $urandom;
      r  = int'($urandom_range(0, 5));
      a1 = $urandom;
      b1 = (r == 0) ? 32'hFFFFFFFF : (r == 1) ? 32'h7FFFFFFF : $urandom;
      do_txn("random", v0, v1, op0, op1, a0, b0, a1, b1, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    rst = 1'b1;
    p0_if.req_valid = 1'b0; p0_if.rsp_ready = 1'b0; p0_if.op = '0; p0_if.a = '0; p0_if.b = '0;
    p1_if.req_valid = 1'b0; p1_if.rsp_ready = 1'b0; p1_if.op = '0; p1_if.a = '0; p1_if.b = '0;
    test_reset();
    test_directed();
    test_contention();
    test_backpressure();
    test_err_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
